// File: rtl/sat_mult_pipe.sv
// sat_mult_pipe: 3-stage signed fixed-point multiplier saturating to a narrow Q-format.
// Define ROUND_NEAREST_EN for round-half-up ahead of the shift (default: floor).
module sat_mult_pipe #(
  parameter int IN_W     = 32,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a_in,
  input  logic [IN_W-1:0]  b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p_out,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             sticky_ovf,
  output logic             sticky_unf,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             clr_status
);

  localparam int SHIFT = 2*IN_FRAC - OUT_FRAC;
  localparam int PW    = 2*IN_W;
  localparam int EW    = PW + 1;

  localparam logic signed [EW-1:0] MAX_E =
    {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_E =
    {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  generate
    if (SHIFT < 1) begin : g_bad_shift
      $error("sat_mult_pipe: 2*IN_FRAC-OUT_FRAC must be >= 1");
    end
  endgenerate

  logic                   stall;
  logic                   xfer;
  logic                   ev_o;
  logic                   ev_u;
  logic                   s1_v;
  logic                   s2_v;
  logic signed [IN_W-1:0] s1_a;
  logic signed [IN_W-1:0] s1_b;
  logic signed [PW-1:0]   s2_p;
  logic signed [EW-1:0]   ext;
  logic signed [EW-1:0]   shv;
  logic [OUT_W-1:0]       sat_p;
  logic                   sat_o;
  logic                   sat_u;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign xfer     = out_valid && out_ready;
  assign ev_o     = xfer && out_ovf;
  assign ev_u     = xfer && out_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s2_v <= 1'b0;
      s2_p <= '0;
    end else if (!stall) begin
      s1_v <= in_valid;
      s1_a <= a_in;
      s1_b <= b_in;
      s2_v <= s1_v;
      s2_p <= s1_a * s1_b;
    end
  end

  // One extra bit keeps the rounding add from wrapping.
  always_comb begin
`ifdef ROUND_NEAREST_EN
    ext = {s2_p[PW-1], s2_p} + (MAX_E - MAX_E + ({{(EW-1){1'b0}}, 1'b1} << (SHIFT-1)));
`else
    ext = {s2_p[PW-1], s2_p};
`endif
    shv   = ext >>> SHIFT;
    sat_o = shv > MAX_E;
    sat_u = shv < MIN_E;
    sat_p = shv[OUT_W-1:0];
    if (sat_o) sat_p = MAX_E[OUT_W-1:0];
    if (sat_u) sat_p = MIN_E[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p_out     <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_v;
      p_out     <= sat_p;
      out_ovf   <= sat_o;
      out_unf   <= sat_u;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      sticky_ovf <= ev_o || (sticky_ovf && !clr_status);
      sticky_unf <= ev_u || (sticky_unf && !clr_status);
      if (ev_o || ev_u) begin
        if (clr_status)
          sat_cnt <= CNT_ONE;
        else if (sat_cnt != CNT_MAX)
          sat_cnt <= sat_cnt + CNT_ONE;
      end else if (clr_status) begin
        sat_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/sat_mult_pipe.md
Name: sat_mult_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier with saturation to a narrower output format. It is the streaming successor of the combinational capped multiplier in the gradient-descent datapath. Adds valid/ready handshake with backpressure, generic Q-formats, sticky saturation status and a saturation event counter. Sits between the gradient/parameter registers and the narrow Q8.8 update bus.

Parameters:
IN_W, 32, input operand width (signed, two's complement)
IN_FRAC, 8, fractional bits of both inputs
OUT_W, 16, output width (signed)
OUT_FRAC, 8, fractional bits of output
CNT_W, 16, saturation event counter width
Derived: SHIFT = 2*IN_FRAC - OUT_FRAC. Must be >= 1; elaboration error otherwise.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
a_in  in  IN_W  operand A, Q(IN_W-IN_FRAC).IN_FRAC
b_in  in  IN_W  operand B, same format
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
p_out  out  OUT_W  product, Q(OUT_W-OUT_FRAC).OUT_FRAC, saturated
out_ovf  out  1  this result clamped to max
out_unf  out  1  this result clamped to min
sticky_ovf  out  1  any overflow since last clear
sticky_unf  out  1  any underflow since last clear
sat_cnt  out  CNT_W  count of saturated results delivered
clr_status  in  1  synchronous clear of sticky flags and sat_cnt

Behaviour:
- Reset (rst_n low, async): all stage valids, out_valid, p_out, out_ovf, out_unf, sticky_*, sat_cnt = 0. Reset mid-operation discards all in-flight data. in_ready = 1 out of reset.
- Pipeline, 3 stages: S1 registers a_in/b_in. S2 registers the full 2*IN_W signed product. S3 rounds, shifts, saturates and drives p_out/out_ovf/out_unf.
- Latency: 3 cycles from an accepted input (in_valid && in_ready at edge) to out_valid, when not stalled. Throughput: 1 per cycle.
- Stall = out_valid && !out_ready. While stalled, all stages hold and in_ready = 0. Otherwise in_ready = 1. Bubbles are not compressed.
- Output is held stable (p_out, flags) while out_valid && !out_ready. A transfer occurs when out_valid && out_ready.
- Arithmetic: product computed in 2*IN_W bits. Shift is arithmetic right by SHIFT (floor toward -inf). Compare in 2*IN_W+1 bits with sign-extended limits:
  - MAX = 2^(OUT_W-1)-1. If value > MAX: out_ovf = 1, p_out = MAX.
  - MIN = -2^(OUT_W-1). If value < MIN: out_unf = 1, p_out = MIN.
  - Otherwise p_out = value[OUT_W-1:0]. out_ovf and out_unf are never both 1.
- Status is updated on output transfer only, not while held.
  - sticky_ovf/sticky_unf set when a transferred result has the flag.
  - sat_cnt increments by 1 per saturated transfer and saturates at 2^CNT_W-1; no wrap.
- clr_status: clears sticky_* and sat_cnt next edge. If a saturated transfer happens in the same cycle, the event wins: sticky set, sat_cnt = 1.

Optional Feature:
ROUND_NEAREST_EN
- Defined: S3 adds 2^(SHIFT-1) to the product, computed in 2*IN_W+1 bits so no wrap, before the arithmetic shift. This is round-half-up. Saturation is checked after rounding.
- Undefined: plain truncation (floor), no adder. Latency identical in both builds.

Test Plan:
- a=0x00000100 (1.0), b=0x00000280 (2.5), out_ready=1 -> 3 cycles later p_out=0x0280, out_ovf=0, out_unf=0.
- a=0x00007F00 (127), b=0x00000200 (2) -> p_out=0x7FFF, out_ovf=1, sticky_ovf=1, sat_cnt=1. Then a=0xFFFF8000 (-128), b=0x00000200 -> p_out=0x8000, out_unf=1, sat_cnt=2.
- Boundary: a=0xFFFF8000 (-128), b=0x00000100 (1.0) -> p_out=0x8000, out_unf=0. a=0x00007FFF, b=0x00000100 -> p_out=0x7FFF, out_ovf=0.
- Backpressure: stream 6 back-to-back inputs with out_ready low for cycles 4-7 -> in_ready=0 during stall, first result held stable, all 6 results delivered in order, none lost or duplicated.
- Rounding: a=0x00000001, b=0x00000080 -> p_out=0x0000 without macro, 0x0001 with ROUND_NEAREST_EN. a=0xFFFFFFFF, b=0x00000080 -> 0xFFFF without, 0x0000 with.
- Status/reset:
  - clr_status asserted in the same cycle as a saturated transfer -> sticky=1, sat_cnt=1.
  - Preload sat_cnt to 0xFFFF (CNT_W=16), then another saturation -> stays 0xFFFF.
  - rst_n pulsed low mid-stream -> out_valid drops immediately; no stale result after release.
